// File: rtl/pingpong_buf_ctrl_if.sv
// Pixel-side, transmit-side and RAM-strobe signals of the ping-pong buffer.
// The controller uses the slave view; the data source/sink uses master.
interface pingpong_buf_ctrl_if #(
   parameter int ADDR_W = 14
);
   logic              din_valid;
   logic              sof;
   logic              wr_en_a;
   logic              wr_en_b;
   logic [ADDR_W-1:0] wr_addr;
   logic              tx_req;
   logic              tx_ack;
   logic              rd_req;
   logic              rd_en_a;
   logic              rd_en_b;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic              rd_last;
   logic              overflow;
   logic [15:0]       drop_cnt;

   modport master (
      output din_valid, sof, tx_ack, rd_req,
      input  wr_en_a, wr_en_b, wr_addr, tx_req,
      input  rd_en_a, rd_en_b, rd_addr, rd_valid, rd_last,
      input  overflow, drop_cnt
   );

   modport slave (
      input  din_valid, sof, tx_ack, rd_req,
      output wr_en_a, wr_en_b, wr_addr, tx_req,
      output rd_en_a, rd_en_b, rd_addr, rd_valid, rd_last,
      output overflow, drop_cnt
   );
endinterface

// File: rtl/pingpong_buf_ctrl.sv
// Two-bank packet buffer controller: pixels fill one bank while the
// other is handed to the transmitter and drained byte by byte.
module pingpong_buf_ctrl #(
   parameter int PKT_SIZE = 60,
   parameter int ADDR_W   = 14,
   parameter int RD_LAT   = 2
) (
   input logic                clk,
   input logic                rst,
   pingpong_buf_ctrl_if.slave bus
);

   localparam logic [1:0] ST_EMPTY    = 2'd0;
   localparam logic [1:0] ST_FILLING  = 2'd1;
   localparam logic [1:0] ST_FULL     = 2'd2;
   localparam logic [1:0] ST_DRAINING = 2'd3;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PKT_SIZE - 1);

   logic [1:0][1:0]   st_q, st_d;
   logic              wsel_q, wsel_d;
   logic              rsel_q, rsel_d;
   logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [RD_LAT-1:0] vpipe_q, vpipe_d;
   logic [RD_LAT-1:0] lpipe_q, lpipe_d;
   logic              overflow_q, overflow_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;

   logic [1:0]        w_st;
   logic [ADDR_W-1:0] wr_base;
   logic              wr_ok;
   logic              wr_drop;
   logic              tx_req;
   logic              rd_ok;
   logic              rd_fin;

   always_comb begin
      st_d       = st_q;
      wsel_d     = wsel_q;
      rsel_d     = rsel_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;

      // sof restarts the packet, and a byte arriving with it lands at 0
      w_st    = st_q[wsel_q];
      wr_base = bus.sof ? '0 : wr_cnt_q;
      wr_ok   = bus.din_valid && !rst &&
                (w_st == ST_EMPTY || w_st == ST_FILLING);
      wr_drop = bus.din_valid && !rst && !wr_ok;

      if (bus.sof) wr_cnt_d = '0;
      if (wr_ok) begin
         if (wr_base == LAST) begin
            st_d[wsel_q] = ST_FULL;
            wr_cnt_d     = '0;
            wsel_d       = ~wsel_q;
         end else begin
            st_d[wsel_q] = ST_FILLING;
            wr_cnt_d     = wr_base + ADDR_W'(1);
         end
      end
      if (wr_drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end

      // writer only touches EMPTY/FILLING banks, reader only FULL/DRAINING
      tx_req = !rst && (st_q[rsel_q] == ST_FULL);
      if (tx_req && bus.tx_ack) st_d[rsel_q] = ST_DRAINING;

      rd_ok  = !rst && bus.rd_req && (st_q[rsel_q] == ST_DRAINING);
      rd_fin = rd_ok && (rd_cnt_q == LAST);
      if (rd_ok) begin
         if (rd_fin) begin
            st_d[rsel_q] = ST_EMPTY;
            rd_cnt_d     = '0;
            rsel_d       = ~rsel_q;
         end else begin
            rd_cnt_d = rd_cnt_q + ADDR_W'(1);
         end
      end

      vpipe_d    = vpipe_q;
      lpipe_d    = lpipe_q;
      vpipe_d[0] = rd_ok;
      lpipe_d[0] = rd_fin;
      for (int i = 1; i < RD_LAT; i++) begin
         vpipe_d[i] = vpipe_q[i-1];
         lpipe_d[i] = lpipe_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q       <= {ST_EMPTY, ST_EMPTY};
         wsel_q     <= 1'b0;
         rsel_q     <= 1'b0;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         vpipe_q    <= '0;
         lpipe_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         st_q       <= st_d;
         wsel_q     <= wsel_d;
         rsel_q     <= rsel_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         vpipe_q    <= vpipe_d;
         lpipe_q    <= lpipe_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.wr_en_a  = wr_ok && !wsel_q;
   assign bus.wr_en_b  = wr_ok && wsel_q;
   assign bus.wr_addr  = rst ? '0 : wr_base;
   assign bus.tx_req   = tx_req;
   assign bus.rd_en_a  = rd_ok && !rsel_q;
   assign bus.rd_en_b  = rd_ok && rsel_q;
   assign bus.rd_addr  = rst ? '0 : rd_cnt_q;
   assign bus.rd_valid = !rst && vpipe_q[RD_LAT-1];
   assign bus.rd_last  = !rst && lpipe_q[RD_LAT-1];
   assign bus.overflow = !rst && overflow_q;
   assign bus.drop_cnt = rst ? '0 : drop_cnt_q;

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Directed bench for pingpong_buf_ctrl with 4-byte packets, read latency 2.
module tb_pingpong_buf_ctrl;

   localparam int PKT = 4;
   localparam int AW  = 14;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   pingpong_buf_ctrl_if #(.ADDR_W(AW)) bus ();

   pingpong_buf_ctrl #(
      .PKT_SIZE (PKT),
      .ADDR_W   (AW),
      .RD_LAT   (LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      bus.din_valid = 1'b0;
      bus.sof       = 1'b0;
      bus.tx_ack    = 1'b0;
      bus.rd_req    = 1'b0;
   endtask

   task automatic do_reset;
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wr(input int addr, input int b, input string tag);
      bus.din_valid = 1'b1;
      #1;
      chk({tag, "_en_a"}, int'(bus.wr_en_a), int'(b == 0));
      chk({tag, "_en_b"}, int'(bus.wr_en_b), int'(b == 1));
      chk({tag, "_addr"}, int'(bus.wr_addr), addr);
      tick();
      bus.din_valid = 1'b0;
   endtask

   initial begin
      int nbytes;
      int rdl;
      bit dv;

      idle();
      rst = 1'b1;
      bus.din_valid = 1'b1;
      bus.rd_req    = 1'b1;
      tick();
      #1;
      chk("rst_wr_en_a", int'(bus.wr_en_a), 0);
      chk("rst_wr_en_b", int'(bus.wr_en_b), 0);
      chk("rst_tx_req", int'(bus.tx_req), 0);
      chk("rst_rd_valid", int'(bus.rd_valid), 0);
      chk("rst_overflow", int'(bus.overflow), 0);
      chk("rst_drop_cnt", int'(bus.drop_cnt), 0);
      tick();
      rst = 1'b0;
      idle();

      // one packet into A, writer moves to B
      for (int i = 0; i < 4; i++) wr(i, 0, "t1_wr");
      #1;
      chk("t1_tx_req", int'(bus.tx_req), 1);
      wr(0, 1, "t1_wsel");
      do_reset();

      // ack with no packet pending is ignored; then fill, ack, drain
      bus.tx_ack = 1'b1;
      tick();
      bus.tx_ack = 1'b0;
      for (int i = 0; i < 4; i++) wr(i, 0, "t2_wr");
      #1;
      chk("t2_tx_req", int'(bus.tx_req), 1);
      bus.tx_ack = 1'b1;
      tick();
      bus.tx_ack = 1'b0;
      #1;
      chk("t2_tx_drop", int'(bus.tx_req), 0);
      for (int i = 0; i < 7; i++) begin
         bus.rd_req = (i < 4);
         #1;
         chk("t2_rd_en_a", int'(bus.rd_en_a), int'(i < 4));
         chk("t2_rd_en_b", int'(bus.rd_en_b), 0);
         if (i < 4) chk("t2_rd_addr", int'(bus.rd_addr), i);
         chk("t2_rd_valid", int'(bus.rd_valid), int'(i >= 2 && i <= 5));
         chk("t2_rd_last", int'(bus.rd_last), int'(i == 5));
         tick();
      end
      bus.rd_req = 1'b1;
      #1;
      chk("t2_ign_a", int'(bus.rd_en_a), 0);
      chk("t2_ign_b", int'(bus.rd_en_b), 0);
      tick();
      bus.rd_req = 1'b0;
      for (int i = 0; i < 4; i++) wr(i, 1, "t2_wr_b");
      wr(0, 0, "t2_a_empty");
      do_reset();

      // no transmitter: both banks fill, last 4 bytes dropped
      for (int i = 0; i < 12; i++) begin
         bus.din_valid = 1'b1;
         #1;
         chk("t3_en_a", int'(bus.wr_en_a), int'(i < 4));
         chk("t3_en_b", int'(bus.wr_en_b), int'(i >= 4 && i < 8));
         chk("t3_drop", int'(bus.drop_cnt), (i < 8) ? 0 : i - 8);
         tick();
      end
      bus.din_valid = 1'b0;
      #1;
      chk("t3_overflow", int'(bus.overflow), 1);
      chk("t3_drop_cnt", int'(bus.drop_cnt), 4);
      chk("t3_tx_req", int'(bus.tx_req), 1);
      do_reset();
      #1;
      chk("t3_rst_ovf", int'(bus.overflow), 0);
      chk("t3_rst_cnt", int'(bus.drop_cnt), 0);

      // sof restarts the packet at address 0
      wr(0, 0, "t4_wr");
      wr(1, 0, "t4_wr");
      bus.sof = 1'b1;
      wr(0, 0, "t4_sof");
      bus.sof = 1'b0;
      wr(1, 0, "t4_wr");
      wr(2, 0, "t4_wr");
      #1;
      chk("t4_tx_early", int'(bus.tx_req), 0);
      wr(3, 0, "t4_wr");
      #1;
      chk("t4_tx_req", int'(bus.tx_req), 1);
      do_reset();

      // paced stream, drain keeps up; includes drain/toggle on one edge
      nbytes = 0;
      rdl    = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         dv = (cyc % 5 != 2);
         bus.din_valid = dv;
         bus.rd_req    = 1'b1;
         #1;
         bus.tx_ack = bus.tx_req;
         if (dv) begin
            chk("t5_en_a", int'(bus.wr_en_a), int'((nbytes / PKT) % 2 == 0));
            chk("t5_en_b", int'(bus.wr_en_b), int'((nbytes / PKT) % 2 == 1));
            chk("t5_addr", int'(bus.wr_addr), nbytes % PKT);
            nbytes++;
         end else begin
            chk("t5_no_wr", int'(bus.wr_en_a | bus.wr_en_b), 0);
         end
         if (bus.rd_last) rdl++;
         tick();
      end
      idle();
      #1;
      chk("t5_drop_cnt", int'(bus.drop_cnt), 0);
      chk("t5_overflow", int'(bus.overflow), 0);
      chk("t5_pkts", rdl, 6);
      do_reset();

      // reset in the middle of a drain
      for (int i = 0; i < 4; i++) wr(i, 0, "t6_wr");
      bus.tx_ack = 1'b1;
      tick();
      bus.tx_ack = 1'b0;
      bus.rd_req = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t6_tx_req", int'(bus.tx_req), 0);
      chk("t6_rd_en_a", int'(bus.rd_en_a), 0);
      chk("t6_rd_en_b", int'(bus.rd_en_b), 0);
      chk("t6_rd_valid", int'(bus.rd_valid), 0);
      bus.rd_req = 1'b0;
      wr(0, 0, "t6_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
